// File: rtl/layer6_fetch.sv
// Read-side sequencer for the layer-6 result RAM: issues NUM_WORDS reads per frame,
// buffers read data in a 2-entry FIFO and streams it out with last/done marking.
module layer6_fetch #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 7,
    parameter int NUM_WORDS = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   out_idx_q, out_idx_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         fifo_count_q, fifo_count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_q [2];
    logic [DATA_W-1:0]  mem_d [2];
    logic               done_q, done_d;

    logic               pop;
    logic [2:0]         occupancy;

    always_comb begin
        m_valid   = (fifo_count_q != 2'd0);
        m_data    = mem_q[rd_ptr_q];
        m_last    = m_valid && (out_idx_q == CNT_W'(NUM_WORDS - 1));
        pop       = m_valid && m_ready;
        busy      = (state_q == FETCH) || (state_q == DRAIN);
        done      = done_q;
        // Occupancy counts the read still in flight so the FIFO can never overflow.
        occupancy = 3'(fifo_count_q) + 3'(inflight_q) - 3'(pop);
        rd_en     = (state_q == FETCH) && (issued_q < CNT_W'(NUM_WORDS)) && (occupancy <= 3'd1);
        rd_addr   = (state_q == FETCH) ? ADDR_W'(BASE_ADDR) + ADDR_W'(issued_q)
                                       : ADDR_W'(BASE_ADDR);
    end

    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q + CNT_W'(rd_en);
        out_idx_d    = out_idx_q + CNT_W'(pop);
        inflight_d   = rd_en;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q + 2'(inflight_q) - 2'(pop);
        done_d       = 1'b0;

        if (inflight_q) begin
            mem_d[wr_ptr_q] = rd_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (issued_q == CNT_W'(NUM_WORDS)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            issued_d     = '0;
            out_idx_d    = '0;
            inflight_d   = 1'b0;
            fifo_count_d = '0;
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issued_q     <= '0;
            out_idx_q    <= '0;
            inflight_q   <= 1'b0;
            fifo_count_q <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            mem_q        <= '{default: '0};
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            out_idx_q    <= out_idx_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_layer6_fetch.sv
// Directed bench for layer6_fetch: RAM model holds RAM[a] = a replicated in 32-bit lanes.
module tb_layer6_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         rd_en;
    logic [6:0]   rd_addr;
    logic [511:0] rd_data;
    logic         m_valid;
    logic         m_ready;
    logic [511:0] m_data;
    logic         m_last;
    logic         busy;
    logic         done;

    layer6_fetch #(
        .DATA_W   (512),
        .ADDR_W   (7),
        .NUM_WORDS(16),
        .BASE_ADDR(0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_last (m_last),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= {16{32'(rd_addr)}};
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int max_cnt  = 0;

    int rd_cyc_q[$];
    int rd_addr_q[$];
    int acc_cyc_q[$];
    int acc_val_q[$];
    bit acc_last_q[$];
    bit acc_rep_q[$];
    int done_q[$];
    int busy_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(int'(rd_addr));
        end
        if (m_valid && m_ready) begin
            acc_cyc_q.push_back(cyc);
            acc_val_q.push_back(int'(m_data[31:0]));
            acc_last_q.push_back(m_last);
            acc_rep_q.push_back(m_data == {16{m_data[31:0]}});
        end
        if (done) done_q.push_back(cyc);
        if (busy) busy_q.push_back(cyc);
        if (int'(dut.fifo_count_q) > max_cnt) max_cnt = int'(dut.fifo_count_q);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_cyc_q.delete();  rd_addr_q.delete();
        acc_cyc_q.delete(); acc_val_q.delete();
        acc_last_q.delete(); acc_rep_q.delete();
        done_q.delete();    busy_q.delete();
        max_cnt = 0;
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s     = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_nwords"}, acc_val_q.size(), 16);
        foreach (acc_val_q[i]) begin
            check({tag, "_data"}, acc_val_q[i], i % 16);
            check({tag, "_last"}, acc_last_q[i], (i % 16) == 15);
            check({tag, "_rep"}, acc_rep_q[i], 1);
        end
        check({tag, "_ndone"}, done_q.size(), 1);
        if (done_q.size() > 0 && acc_cyc_q.size() > 0)
            check({tag, "_done_cyc"}, done_q[0], acc_cyc_q[acc_cyc_q.size()-1] + 1);
    endtask

    task automatic stream_timing(input string tag, input int s);
        check({tag, "_nreads"}, rd_addr_q.size(), 16);
        foreach (rd_addr_q[i]) begin
            check({tag, "_rd_addr"}, rd_addr_q[i], i);
            check({tag, "_rd_cyc"}, rd_cyc_q[i], s + 1 + i);
        end
        foreach (acc_cyc_q[i]) check({tag, "_acc_cyc"}, acc_cyc_q[i], s + 3 + i);
        if (done_q.size() > 0) check({tag, "_done_at"}, done_q[0], s + 19);
        check({tag, "_nbusy"}, busy_q.size(), 18);
        if (busy_q.size() > 0) begin
            check({tag, "_busy_first"}, busy_q[0], s + 1);
            check({tag, "_busy_last"}, busy_q[busy_q.size()-1], s + 18);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data_zero"}, m_data == '0, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int s, s2;
        rst = 1'b1; start = 1'b0; m_ready = 1'b1; rd_data = '0;
        step(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        step(2);

        // Streaming with m_ready held high
        clear_logs();
        pulse_start(s);
        step(25);
        stream_timing("stream", s);
        check_frame("stream");

        // Full backpressure, released in cycle 10
        clear_logs();
        m_ready = 1'b0;
        pulse_start(s);
        step(8);
        check("bp_valid_held", m_valid, 1);
        check("bp_data_held", m_data[31:0], 0);
        check("bp_nreads_stalled", rd_addr_q.size(), 2);
        if (rd_addr_q.size() >= 2) begin
            check("bp_rd0", rd_addr_q[0], 0);
            check("bp_rd1", rd_addr_q[1], 1);
        end
        step(1);
        m_ready = 1'b1;
        step(25);
        check_frame("bp");
        foreach (acc_cyc_q[i]) check("bp_acc_cyc", acc_cyc_q[i], s + 10 + i);
        check("bp_fifo_max", max_cnt > 2, 0);

        // Alternating m_ready
        clear_logs();
        m_ready = 1'b1;
        pulse_start(s);
        for (int k = 1; k < 50; k++) begin
            m_ready = (k % 2 == 0);
            step(1);
        end
        m_ready = 1'b1;
        step(2);
        check_frame("alt");
        check("alt_fifo_max", max_cnt > 2, 0);

        // Start pulses while busy
        clear_logs();
        pulse_start(s);
        for (int k = 1; k < 30; k++) begin
            start = (k == 5 || k == 12);
            step(1);
        end
        start = 1'b0;
        stream_timing("busystart", s);
        check_frame("busystart");

        // Reset in cycle 8 of a frame, restart in cycle 10
        clear_logs();
        pulse_start(s);
        step(7);
        rst = 1'b1;
        step(1);
        check_idle_outputs("midrst");
        rst = 1'b0;
        step(1);
        clear_logs();
        pulse_start(s);
        step(25);
        stream_timing("afterrst", s);
        check_frame("afterrst");

        // Back-to-back frames
        clear_logs();
        pulse_start(s);
        step(19);
        pulse_start(s2);
        step(25);
        check("b2b_ndone", done_q.size(), 2);
        if (done_q.size() == 2) begin
            check("b2b_done0", done_q[0], s + 19);
            check("b2b_done1", done_q[1], s2 + 19);
        end
        check("b2b_nwords", acc_val_q.size(), 32);
        foreach (acc_val_q[i]) begin
            check("b2b_data", acc_val_q[i], i % 16);
            check("b2b_last", acc_last_q[i], (i % 16) == 15);
        end
        if (acc_cyc_q.size() == 32) begin
            check("b2b_first1", acc_cyc_q[0], s + 3);
            check("b2b_first2", acc_cyc_q[16], s2 + 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
